// File: rtl/ysyx_lsu_store_buffer_pkg.sv
// Shared store-buffer types: drain FSM states, default depth and store strobe encodings.
// Consumers: ysyx_lsu_store_buffer / ysyx_sb_match (forwarding gated by YSYX_SB_FORWARD_EN).
package ysyx_lsu_store_buffer_pkg;

   localparam int unsigned SB_DEPTH_DEFAULT = 4;

   localparam logic [7:0] SB_STRB_B = 8'h01;
   localparam logic [7:0] SB_STRB_H = 8'h03;
   localparam logic [7:0] SB_STRB_W = 8'h0f;

   typedef enum logic [1:0] {
      SB_IDLE  = 2'd0,
      SB_ISSUE = 2'd1,
      SB_GAP   = 2'd2
   } sb_state_e;

endpackage

// File: rtl/ysyx_sb_match.sv
// Load-probe address match against live store-buffer entries, youngest-entry select.
// With YSYX_SB_FORWARD_EN defined, a fully covering youngest entry forwards instead of stalling.
module ysyx_sb_match
   import ysyx_lsu_store_buffer_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = SB_DEPTH_DEFAULT,
   parameter int unsigned IDX_W  = $clog2(DEPTH),
   parameter int unsigned PTR_W  = IDX_W + 1
) (
   input  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr_i,
   input  logic [DEPTH-1:0][DATA_W-1:0] ent_data_i,
   input  logic [DEPTH-1:0][7:0]        ent_strb_i,
   input  logic [IDX_W-1:0]             head_i,
   input  logic [PTR_W-1:0]             count_i,
   input  logic [ADDR_W-1:0]            ld_addr_i,
   input  logic [7:0]                   ld_strb_i,
   input  logic                         ld_valid_i,
   output logic                         ld_stall_c,
   output logic                         ld_hit_c,
   output logic [DATA_W-1:0]            ld_data_c
);

   logic             any_match;
   logic [IDX_W-1:0] young_idx;
   logic [IDX_W-1:0] idx;

   // Walk oldest to youngest so the last hit is the youngest matching store.
   always_comb begin
      any_match = 1'b0;
      young_idx = '0;
      idx       = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         idx = IDX_W'(head_i + IDX_W'(k));
         if ((PTR_W'(k) < count_i) &&
             (ent_addr_i[idx][ADDR_W-1:2] == ld_addr_i[ADDR_W-1:2])) begin
            any_match = 1'b1;
            young_idx = idx;
         end
      end
   end

`ifdef YSYX_SB_FORWARD_EN
   logic covers;
   assign covers = ((ent_strb_i[young_idx] & ld_strb_i) == ld_strb_i) &&
                   (ent_addr_i[young_idx][1:0] == ld_addr_i[1:0]);

   assign ld_hit_c   = ld_valid_i & any_match & covers;
   assign ld_stall_c = ld_valid_i & any_match & ~covers;
   assign ld_data_c  = ld_hit_c ? ent_data_i[young_idx] : '0;
`else
   logic unused_fwd;
   assign unused_fwd = ^{ent_data_i, ent_strb_i, ent_addr_i, ld_strb_i, ld_addr_i[1:0], young_idx};

   assign ld_hit_c   = 1'b0;
   assign ld_stall_c = ld_valid_i & any_match;
   assign ld_data_c  = '0;
`endif

endmodule

// File: rtl/ysyx_lsu_store_buffer.sv
// LSU store buffer: circular FIFO drained to the bus arbiter by an IDLE/ISSUE/GAP FSM.
// Define YSYX_SB_FORWARD_EN to let covered loads forward from the youngest matching store.
module ysyx_lsu_store_buffer
   import ysyx_lsu_store_buffer_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = SB_DEPTH_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [DATA_W-1:0] st_data,
   input  logic [7:0]        st_strb,
   input  logic              st_valid,
   output logic              st_ready_o,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [7:0]        ld_strb,
   input  logic              ld_valid,
   output logic              ld_stall_o,
   output logic              ld_hit_o,
   output logic [DATA_W-1:0] ld_data_o,
   output logic [ADDR_W-1:0] sb_awaddr_o,
   output logic              sb_awvalid_o,
   output logic [DATA_W-1:0] sb_wdata_o,
   output logic [7:0]        sb_wstrb_o,
   output logic              sb_wvalid_o,
   input  logic              sb_wready,
   output logic              empty_o
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;

   sb_state_e                    state_q, state_d;
   logic [PTR_W-1:0]             head_q, head_d, tail_q, tail_d, count_q, count_d;
   logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
   logic [DEPTH-1:0][DATA_W-1:0] data_q;
   logic [DEPTH-1:0][7:0]        strb_q;
   logic [IDX_W-1:0]             head_idx, tail_idx;
   logic                         push, pop;

   assign head_idx   = head_q[IDX_W-1:0];
   assign tail_idx   = tail_q[IDX_W-1:0];
   // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
   assign st_ready_o = (count_q < PTR_W'(DEPTH));
   assign push       = st_valid & st_ready_o;
   assign pop        = (state_q == SB_ISSUE) & sb_wready;
   assign empty_o    = (count_q == '0) & (state_q == SB_IDLE);

   assign head_d  = head_q + PTR_W'(pop);
   assign tail_d  = tail_q + PTR_W'(push);
   assign count_d = count_q + PTR_W'(push) - PTR_W'(pop);

   // Drain FSM next state and bus outputs; reset gates valids without waiting for the flop.
   always_comb begin
      state_d      = state_q;
      sb_awvalid_o = 1'b0;
      sb_wvalid_o  = 1'b0;
      sb_awaddr_o  = '0;
      sb_wdata_o   = '0;
      sb_wstrb_o   = '0;
      unique case (state_q)
         SB_IDLE: begin
            if (count_q != '0) state_d = SB_ISSUE;
         end
         SB_ISSUE: begin
            sb_awvalid_o = rst;
            sb_wvalid_o  = rst;
            sb_awaddr_o  = addr_q[head_idx];
            sb_wdata_o   = data_q[head_idx];
            sb_wstrb_o   = strb_q[head_idx];
            if (sb_wready) state_d = SB_GAP;
         end
         SB_GAP: begin
            state_d = (count_q != '0) ? SB_ISSUE : SB_IDLE;
         end
         default: state_d = SB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= SB_IDLE;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[tail_idx] <= st_addr;
         data_q[tail_idx] <= st_data;
         strb_q[tail_idx] <= st_strb;
      end
   end

   ysyx_sb_match #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W),
      .PTR_W  (PTR_W)
   ) u_match (
      .ent_addr_i (addr_q),
      .ent_data_i (data_q),
      .ent_strb_i (strb_q),
      .head_i     (head_idx),
      .count_i    (count_q),
      .ld_addr_i  (ld_addr),
      .ld_strb_i  (ld_strb),
      .ld_valid_i (ld_valid),
      .ld_stall_c (ld_stall_o),
      .ld_hit_c   (ld_hit_o),
      .ld_data_c  (ld_data_o)
   );

endmodule

// File: doc/ysyx_lsu_store_buffer.md
YSYX_LSU_STORE_BUFFER -- requirements
Module: ysyx_lsu_store_buffer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, store data width.
REQ-003 SHALL have parameter DEPTH, default 4, entry count, power of two, >=2.
REQ-004 SHALL provide these ports; clock and reset are listed first:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- st_addr  input  ADDR_W  store address from the LSU.
- st_data  input  DATA_W  store data (unshifted).
- st_strb  input  8  byte strobe (8'h1, 8'h3 or 8'hf).
- st_valid  input  1  store request.
- st_ready_o  output  1  entry free.
- ld_addr  input  ADDR_W  load address probe.
- ld_strb  input  8  load byte strobe.
- ld_valid  input  1  load probe active.
- ld_stall_o  output  1  load must wait.
- ld_hit_o  output  1  load served by forwarding.
- ld_data_o  output  DATA_W  forwarded data.
- sb_awaddr_o  output  ADDR_W  to arbiter lsu_awaddr.
- sb_awvalid_o  output  1  to arbiter lsu_awvalid.
- sb_wdata_o  output  DATA_W  to arbiter lsu_wdata.
- sb_wstrb_o  output  8  to arbiter lsu_wstrb.
- sb_wvalid_o  output  1  to arbiter lsu_wvalid.
- sb_wready  input  1  from arbiter lsu_wready_o.
- empty_o  output  1  no pending stores (fence/drain).

Function
REQ-005 SHALL implement a circular FIFO of DEPTH entries {addr, data, strb} with head/tail pointers of log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH.
REQ-006 SHALL set st_ready_o = (count < DEPTH) from the registered count; a store is accepted when st_valid & st_ready_o.
REQ-007 SHALL refuse a push at full even if a pop occurs in the same cycle.
REQ-008 SHALL run the drain FSM with states IDLE, ISSUE and GAP.
- IDLE -> ISSUE when count > 0.
- ISSUE -> GAP when sb_wready is high.
- GAP -> ISSUE if count > 0, else IDLE.
REQ-009 SHALL make a stored entry visible to the drain no earlier than the cycle after its acceptance.
REQ-010 SHALL, in ISSUE only, drive sb_awvalid_o = sb_wvalid_o = 1 with the head entry's fields, held stable until sb_wready.
REQ-011 SHALL pop the head on the ISSUE cycle with sb_wready high, and deassert valids in GAP (one-cycle bubble that lets the arbiter return to ls_a).
REQ-012 SHALL drive sb_* data outputs to 0 outside ISSUE.
REQ-013 SHALL, on simultaneous push and pop, keep count unchanged and update both pointers.
REQ-014 SHALL compare at word granularity (addr[ADDR_W-1:2]) across all valid entries, including the entry in ISSUE.
REQ-015 SHALL assert ld_stall_o = ld_valid & (any match); ld_hit_o = 0 and ld_data_o = 0 when forwarding is compiled out.
REQ-016 SHALL assert empty_o = (count == 0) & (state == IDLE).

Reset
REQ-017 SHALL, while rst is low, asynchronously clear the pointers and count, set state to IDLE, and discard pending stores.
REQ-018 SHALL hold these reset output values: st_ready_o = 1, all valids = 0, ld_stall_o = 0, ld_hit_o = 0, data outputs = 0, empty_o = 1.
REQ-019 SHALL, when reset is asserted mid-ISSUE, drop sb_awvalid_o/sb_wvalid_o combinationally in the same cycle.

Configuration
REQ-020 SHALL support macro YSYX_SB_FORWARD_EN; behaviour with and without it:
- Defined: selects the youngest matching entry.
- Defined, and (entry strb & ld_strb) == ld_strb with identical addr[1:0]: ld_hit_o = 1, ld_data_o = entry data, ld_stall_o = 0.
- Defined, any other match: ld_stall_o = 1.
- Undefined: REQ-015 applies.

Structure
REQ-021 SHALL place the drain state enum, the DEPTH default and the strobe constants (8'h1/8'h3/8'hf) in the shared ysyx package alongside the existing bus macros.
REQ-022 SHALL isolate the address-match/youngest-select logic in sub-module ysyx_sb_match; the FIFO and FSM stay in the top.

Verification
REQ-023 SHALL cover each of the following directed scenarios:
- Single store 0x80000004/0xDEADBEEF/8'hf, sb_wready high 2 cycles later -> sb_awvalid_o one cycle after accept, held, pop, GAP, empty_o = 1 two cycles after pop.
- Four stores back-to-back with sb_wready low -> st_ready_o = 0 after the 4th; fifth store stalled until the first pop, then accepted the following cycle.
- Push at full concurrent with pop -> push refused; count = 3 next cycle.
- Store 0x80000010 pending, load probe 0x80000012 strb 8'h3, forwarding off -> ld_stall_o = 1 until that entry pops.
- YSYX_SB_FORWARD_EN, stores 0x100/0x11111111 then 0x100/0x22222222, load 0x100 8'hf -> ld_hit_o = 1, ld_data_o = 0x22222222; byte store then word load -> stall.
- rst low during ISSUE with 3 entries -> valids low immediately; after release empty_o = 1 and st_ready_o = 1.
